hazard_unit: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage MIPS datapath; companion to the forwarding unit.
//  The forwarding unit resolves hazards that a bypass can fix. This block handles the rest:

---
 rtl/hazard_unit.sv | 111 +++++++++++
 tb/tb_hazard_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, jump flush and two-cycle branch controller for the ID stage
// Optional stall-cycle counter and StallCount port enabled by HAZARD_STALL_CNT_EN.
module hazard_unit (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic       Jump,
  input  logic       Branch,
  input  logic       ALUZero,
  input  logic       MemReadEX,
  input  logic       UseShamt,
  input  logic       UseImmed,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic [4:0] EX_Rw,
  output logic       PCWrite,
  output logic       IFWrite,
  output logic       Bubble,
`ifdef HAZARD_STALL_CNT_EN
  output logic [1:0] AddrSel,
  output logic [31:0] StallCount
`else
  output logic [1:0] AddrSel
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    JUMP_FLUSH = 2'd1,
    BR_RESOLVE = 2'd2,
    BR_FLUSH   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;

  state_t state;
  state_t state_next;
  logic   load_use;
  logic   pc_en;

  // Shamt/immediate forms do not actually read Rs/Rt, so they cannot collide with the load.
  assign load_use = MemReadEX && (EX_Rw != 5'd0) &&
                    (((ID_Rs == EX_Rw) && !UseShamt) || ((ID_Rt == EX_Rw) && !UseImmed));

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_en      = 1'b1;
    Bubble     = 1'b0;
    AddrSel    = SEL_SEQ;
    if (!Reset_L) begin
      state_next = IDLE;
      pc_en      = 1'b0;
      Bubble     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load_use) begin
            pc_en  = 1'b0;
            Bubble = 1'b1;
          end else if (Jump) begin
            AddrSel    = SEL_JUMP;
            state_next = JUMP_FLUSH;
          end else if (Branch) begin
            // Branch moves on to EX while IF/ID keeps a copy that BR_RESOLVE kills.
            pc_en      = 1'b0;
            state_next = BR_RESOLVE;
          end
        end
        JUMP_FLUSH: begin
          Bubble     = 1'b1;
          state_next = IDLE;
        end
        BR_RESOLVE: begin
          Bubble = 1'b1;
          if (ALUZero) begin
            AddrSel    = SEL_BRANCH;
            state_next = BR_FLUSH;
          end else begin
            state_next = IDLE;
          end
        end
        BR_FLUSH: begin
          Bubble     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign PCWrite = pc_en;
  assign IFWrite = pc_en;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_count;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)     stall_count <= 32'd0;
    else if (!pc_en)  stall_count <= stall_count + 32'd1;
  end

  assign StallCount = stall_count;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic       Jump, Branch, ALUZero, MemReadEX, UseShamt, UseImmed;
  logic [4:0] ID_Rs, ID_Rt, EX_Rw;
  logic       PCWrite, IFWrite, Bubble;
  logic [1:0] AddrSel;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] StallCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  hazard_unit dut (
    .CLK(CLK), .Reset_L(Reset_L), .Jump(Jump), .Branch(Branch), .ALUZero(ALUZero),
    .MemReadEX(MemReadEX), .UseShamt(UseShamt), .UseImmed(UseImmed),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_Rw(EX_Rw),
    .PCWrite(PCWrite), .IFWrite(IFWrite), .Bubble(Bubble),
`ifdef HAZARD_STALL_CNT_EN
    .AddrSel(AddrSel), .StallCount(StallCount)
`else
    .AddrSel(AddrSel)
`endif
  );

  // Observed outputs packed as {PCWrite, IFWrite, Bubble, AddrSel}.
  logic [4:0] obs;
  assign obs = {PCWrite, IFWrite, Bubble, AddrSel};

  task automatic clear_inputs();
    Jump = 0; Branch = 0; ALUZero = 0; MemReadEX = 0; UseShamt = 0; UseImmed = 0;
    ID_Rs = 5'd1; ID_Rt = 5'd2; EX_Rw = 5'd3;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset_L = 0;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 5'b00100); end
    next_cycle();
    Reset_L = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
  endtask

  task automatic test_load_use();
    MemReadEX = 1; EX_Rw = 5'd5; ID_Rs = 5'd5; ID_Rt = 5'd9;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL lu_rs_stall got=%b exp=%b", obs, 5'b00100); end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL lu_release got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
    MemReadEX = 1; EX_Rw = 5'd12; ID_Rs = 5'd4; ID_Rt = 5'd12;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL lu_rt_stall got=%b exp=%b", obs, 5'b00100); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_load_use_masked();
    MemReadEX = 1; EX_Rw = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
    EX_Rw = 5'd7; ID_Rs = 5'd3; ID_Rt = 5'd7; UseImmed = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL lu_immed got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
    UseImmed = 0; UseShamt = 1; ID_Rs = 5'd7; ID_Rt = 5'd2;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL lu_shamt got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
    MemReadEX = 0; UseShamt = 0;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL lu_noload got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_jump();
    Jump = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11001) begin bad++; $display("FAIL jump_c0 got=%b exp=%b", obs, 5'b11001); end
    next_cycle();
    // Jump still high and a load-use present: both ignored outside IDLE.
    MemReadEX = 1; EX_Rw = 5'd6; ID_Rs = 5'd6;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11100) begin bad++; $display("FAIL jump_c1 got=%b exp=%b", obs, 5'b11100); end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL jump_c2 got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
  endtask

  task automatic test_priority();
    MemReadEX = 1; EX_Rw = 5'd8; ID_Rs = 5'd8; Jump = 1; Branch = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL lu_over_jump got=%b exp=%b", obs, 5'b00100); end
    next_cycle();
    MemReadEX = 0;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11001) begin bad++; $display("FAIL jump_over_branch got=%b exp=%b", obs, 5'b11001); end
    next_cycle();
    @(negedge CLK);
    total++;
    if (obs !== 5'b11100) begin bad++; $display("FAIL jb_flush got=%b exp=%b", obs, 5'b11100); end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL jb_idle got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
  endtask

  task automatic test_branch_taken();
    Branch = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL bt_stall got=%b exp=%b", obs, 5'b00000); end
    next_cycle();
    ALUZero = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11110) begin bad++; $display("FAIL bt_resolve got=%b exp=%b", obs, 5'b11110); end
    next_cycle();
    @(negedge CLK);
    total++;
    if (obs !== 5'b11100) begin bad++; $display("FAIL bt_flush got=%b exp=%b", obs, 5'b11100); end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL bt_idle got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
  endtask

  task automatic test_branch_not_taken();
    Branch = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL bn_stall got=%b exp=%b", obs, 5'b00000); end
    next_cycle();
    ALUZero = 0;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11100) begin bad++; $display("FAIL bn_resolve got=%b exp=%b", obs, 5'b11100); end
    next_cycle();
    Branch = 0;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL bn_idle got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
  endtask

  task automatic test_reset_mid_branch();
    Branch = 1;
    next_cycle();
    ALUZero = 1; Branch = 0;
    Reset_L = 0;
    #1;
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL midrst_immediate got=%b exp=%b", obs, 5'b00100); end
    next_cycle();
    Reset_L = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b11000) begin bad++; $display("FAIL midrst_idle got=%b exp=%b", obs, 5'b11000); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    // Jump flush followed directly by a branch, then a load-use right after it.
    Jump = 1;
    next_cycle();
    Jump = 0;
    next_cycle();
    Branch = 1;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL b2b_branch got=%b exp=%b", obs, 5'b00000); end
    next_cycle();
    Branch = 0; ALUZero = 0;
    next_cycle();
    MemReadEX = 1; EX_Rw = 5'd31; ID_Rt = 5'd31;
    @(negedge CLK);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL b2b_lu got=%b exp=%b", obs, 5'b00100); end
    next_cycle();
    clear_inputs();
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_count();
    Reset_L = 0;
    next_cycle();
    Reset_L = 1;
    MemReadEX = 1; EX_Rw = 5'd5; ID_Rs = 5'd5;
    next_cycle();
    clear_inputs();
    Branch = 1;
    next_cycle();
    Branch = 0; ALUZero = 1;
    next_cycle();
    ALUZero = 0;
    next_cycle();
    next_cycle();
    total++;
    if (StallCount !== 32'd2) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", StallCount, 2); end
    dut.stall_count = 32'hFFFF_FFFE;
    MemReadEX = 1; EX_Rw = 5'd5; ID_Rs = 5'd5;
    next_cycle();
    total++;
    if (StallCount !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stall_max got=%h exp=%h", StallCount, 32'hFFFF_FFFF); end
    next_cycle();
    total++;
    if (StallCount !== 32'd0) begin bad++; $display("FAIL stall_wrap got=%h exp=%h", StallCount, 32'd0); end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_load_use_masked();
    test_jump();
    test_priority();
    test_branch_taken();
    test_branch_not_taken();
    test_reset_mid_branch();
    test_back_to_back();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
